// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter.
// Frame length follows UART_TX_PARITY_EN (even parity bit when defined).
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    localparam logic [15:0] DEFAULT_BAUD_DIVIDER = 16'h013F;
    localparam int          DATA_W               = 8;
    localparam int          FRAME_BITS_8N1       = 10;
    localparam int          FRAME_BITS_PARITY    = 11;

`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = FRAME_BITS_PARITY;
`else
    localparam int FRAME_BITS = FRAME_BITS_8N1;
`endif

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO buffering words between the sender and the line.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] data_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW:0]       wr_q, wr_d;
    logic [AW:0]       rd_q, rd_d;
    logic              do_push;
    logic              do_pop;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                     (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign data_o  = mem_q[rd_q[AW-1:0]];

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (do_push) wr_d = wr_q + 1'b1;
        if (do_pop)  rd_d = rd_q + 1'b1;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 8N1 frames from an internal FIFO.
// Define UART_TX_PARITY_EN to insert an even parity bit before stop.
module uart_tx
    import uart_pkg::*;
#(
    parameter logic [15:0] BAUD_DIVIDER = DEFAULT_BAUD_DIVIDER,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              en_i,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              tx_valid_i,
    output logic              tx_ready_o,
    output logic              tx_o,
    output logic              tx_busy_o,
    output logic              tx_div_clk_en_o
);

    uart_state_e       state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [2:0]        bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
    logic              par_q, par_d;
`endif

    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    logic [DATA_W-1:0] fifo_data;
    logic              wrap;
    logic              start_ok;

    uart_tx_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .push_i (tx_valid_i),
        .data_i (tx_data_i),
        .pop_i  (fifo_pop),
        .data_o (fifo_data),
        .full_o (fifo_full),
        .empty_o(fifo_empty)
    );

    assign wrap     = (state_q != IDLE) &&
                      (cnt_q == BAUD_DIVIDER - 16'd1);
    assign start_ok = ~fifo_empty & en_i;

    always_comb begin
        state_d  = state_q;
        cnt_d    = '0;
        bit_d    = bit_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        fifo_pop = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d    = par_q;
`endif
        if (state_q != IDLE && !wrap) cnt_d = cnt_q + 16'd1;

        unique case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (start_ok) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_data;
`ifdef UART_TX_PARITY_EN
                    par_d    = ^fifo_data;
`endif
                    tx_d     = 1'b0;
                    state_d  = START;
                end
            end
            START: begin
                if (wrap) begin
                    state_d = DATA;
                    tx_d    = shift_q[0];
                    shift_d = {1'b0, shift_q[DATA_W-1:1]};
                    bit_d   = 3'd7;
                end
            end
            DATA: begin
                if (wrap) begin
                    if (bit_q == 3'd0) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
                        tx_d    = par_q;
`else
                        state_d = STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        tx_d    = shift_q[0];
                        shift_d = {1'b0, shift_q[DATA_W-1:1]};
                        bit_d   = bit_q - 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (wrap) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            STOP: begin
                if (wrap) begin
                    // Chain straight into the next start bit when possible.
                    if (start_ok) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_data;
`ifdef UART_TX_PARITY_EN
                        par_d    = ^fifo_data;
`endif
                        tx_d     = 1'b0;
                        state_d  = START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign tx_o            = tx_q;
    assign tx_ready_o      = ~fifo_full;
    assign tx_busy_o       = (state_q != IDLE) | ~fifo_empty;
    assign tx_div_clk_en_o = wrap;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx with BAUD_DIVIDER = 4, FIFO_DEPTH = 4.
// Define UART_TX_PARITY_EN to also cover the parity frame format.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int BD = 4;

    logic       clk = 1'b0;
    logic       reset_i = 1'b1;
    logic       en_i = 1'b1;
    logic [7:0] tx_data_i = 8'h00;
    logic       tx_valid_i = 1'b0;
    logic       tx_ready_o;
    logic       tx_o;
    logic       tx_busy_o;
    logic       tx_div_clk_en_o;

    int n_checks = 0;
    int n_err = 0;
    int cyc = 0;
    int pulses = 0;

    uart_tx #(
        .BAUD_DIVIDER(16'd4),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk_i          (clk),
        .reset_i        (reset_i),
        .en_i           (en_i),
        .tx_data_i      (tx_data_i),
        .tx_valid_i     (tx_valid_i),
        .tx_ready_o     (tx_ready_o),
        .tx_o           (tx_o),
        .tx_busy_o      (tx_busy_o),
        .tx_div_clk_en_o(tx_div_clk_en_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (tx_div_clk_en_o) pulses <= pulses + 1;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) step();
    endtask

    function automatic logic [10:0] frame_of(input logic [7:0] d);
`ifdef UART_TX_PARITY_EN
        return {1'b1, ^d, d, 1'b0};
`else
        return {1'b1, 1'b1, d, 1'b0};
`endif
    endfunction

    task automatic send_frame(input logic [7:0] d, input string tag);
        logic [10:0] f;
        int s;
        int p;
        f = frame_of(d);
        tx_valid_i = 1'b1;
        tx_data_i  = d;
        step();
        tx_valid_i = 1'b0;
        chk({tag, "_lat0"}, tx_o, 1);
        step();
        chk({tag, "_lat1"}, tx_o, 0);
        s = cyc;
        p = pulses;
        for (int b = 0; b < FB; b++) begin
            wait_cyc(s + BD * b + 2);
            chk($sformatf("%s_bit%0d", tag, b), tx_o, f[b]);
        end
        while (tx_busy_o && cyc < s + 200) step();
        chk({tag, "_len"}, cyc - s, FB * BD);
        chk({tag, "_pulses"}, pulses - p, FB);
    endtask

    logic [7:0]  words [5];
    logic [63:0] rx_bits;
    logic [7:0]  rx_byte;
    int          c0;
    int          s0;
    logic        bad;

    initial begin
        words[0] = 8'h11;
        words[1] = 8'h22;
        words[2] = 8'h3C;
        words[3] = 8'h81;
        words[4] = 8'hFE;
        rx_bits  = '0;

        // reset state
        step();
        step();
        chk("rst_tx", tx_o, 1);
        chk("rst_ready", tx_ready_o, 1);
        chk("rst_busy", tx_busy_o, 0);
        chk("rst_div", tx_div_clk_en_o, 0);
        reset_i = 1'b0;
        step();
        chk("idle_tx", tx_o, 1);
        chk("idle_busy", tx_busy_o, 0);

        // single frame
        send_frame(8'hA5, "a5");

        // burst of five words into a four-deep FIFO
        step();
        c0 = cyc;
        for (int i = 0; i < 5; i++) begin
            tx_valid_i = 1'b1;
            tx_data_i  = words[i];
            chk($sformatf("burst_rdy%0d", i), tx_ready_o, 1);
            step();
        end
        chk("burst_full", tx_ready_o, 0);
        tx_data_i = 8'h66;
        for (int b = 0; b < 5 * FB; b++) begin
            wait_cyc(c0 + 2 + BD * b + 3);
            rx_bits[b] = tx_o;
            if (b == 2) begin
                chk("burst_stall", tx_ready_o, 0);
                tx_valid_i = 1'b0;
            end
        end
        for (int k = 0; k < 5; k++) begin
            for (int j = 0; j < 8; j++) rx_byte[j] = rx_bits[k * FB + 1 + j];
            chk($sformatf("burst_start%0d", k), rx_bits[k * FB], 0);
            chk($sformatf("burst_byte%0d", k), rx_byte, words[k]);
            chk($sformatf("burst_stop%0d", k), rx_bits[k * FB + FB - 1], 1);
        end
        wait_cyc(c0 + 2 + 5 * FB * BD + 1);
        chk("burst_done_busy", tx_busy_o, 0);
        chk("burst_done_rdy", tx_ready_o, 1);

        // enable gating
        en_i       = 1'b0;
        tx_valid_i = 1'b1;
        tx_data_i  = 8'h5A;
        step();
        tx_valid_i = 1'b0;
        repeat (5) step();
        chk("en_hold_tx", tx_o, 1);
        chk("en_hold_busy", tx_busy_o, 1);
        en_i = 1'b1;
        step();
        chk("en_start", tx_o, 0);
        s0 = cyc;

        // queue one more word, then reset in the middle of data bit 2
        tx_valid_i = 1'b1;
        tx_data_i  = 8'h77;
        step();
        tx_valid_i = 1'b0;
        wait_cyc(s0 + BD * 3 + 1);
        chk("mid_data_bit2", tx_o, 0);
        reset_i = 1'b1;
        #1;
        chk("async_rst_tx", tx_o, 1);
        chk("async_rst_busy", tx_busy_o, 0);
        chk("async_rst_rdy", tx_ready_o, 1);
        step();
        reset_i = 1'b0;
        bad = 1'b0;
        repeat (60) begin
            step();
            if (tx_o !== 1'b1 || tx_busy_o !== 1'b0) bad = 1'b1;
        end
        chk("post_rst_quiet", bad, 0);

`ifdef UART_TX_PARITY_EN
        send_frame(8'h07, "p07");
        send_frame(8'h03, "p03");
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter that serializes 8-bit words onto a single line as 8N1 frames: start bit, 8 data bits LSB first, stop bit. Optionally an even-parity bit precedes the stop bit. A small internal FIFO decouples the sending logic (e.g. the SAR result streamer) from the line rate through a valid/ready handshake. It is the transmit counterpart of the UART receiver, uses the same baud divider, and produces the same debug baud-enable pulse.

## Interface
- BAUD_DIVIDER, 16'h013F: clk cycles per bit (36.75 MHz / 115200 = 319); must be ≥ 2
- FIFO_DEPTH, 4: word slots; power of two, ≥ 2
- clk_i  input  1  system clock
- reset_i  input  1  asynchronous, active-high reset
- en_i  input  1  permits starting new frames; a frame already in progress always completes
- tx_data_i  input  8  word to send
- tx_valid_i  input  1  tx_data_i is valid
- tx_ready_o  output  1  FIFO can accept a word (= not full)
- tx_o  output  1  serial line, idle high, registered
- tx_busy_o  output  1  frame in progress or FIFO non-empty
- tx_div_clk_en_o  output  1  debug: one-cycle pulse at every bit boundary

## Operation
- Handshake: a word is written on the clock edge where tx_valid_i & tx_ready_o. Data is ignored when tx_ready_o = 0. tx_data_i is sampled only on that edge.
- FSM states:
  - IDLE: tx_o = 1, baud counter held at 0. If FIFO non-empty & en_i: pop the head into the shift register, drive tx_o = 0, go to START.
  - START → DATA after BAUD_DIVIDER cycles.
  - DATA: 8 bits, shift register LSB first, each held BAUD_DIVIDER cycles. Bit counter 3 bits, 7 → 0.
  - DATA → PARITY (macro on) or STOP.
  - PARITY: XOR of the 8 data bits, held BAUD_DIVIDER cycles.
  - STOP: tx_o = 1 for BAUD_DIVIDER cycles. At its last cycle: if FIFO non-empty & en_i, pop and go straight to START (no idle gap); else go to IDLE.
- Baud counter: 16 bit, counts 0..BAUD_DIVIDER-1 while not IDLE. At wrap it reloads to 0 and pulses tx_div_clk_en_o for one cycle, and the FSM advances.
- FIFO: simultaneous push and pop in the same cycle are both performed and the count is unchanged. Push while full is impossible, since ready is low. Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally.
- en_i deasserted: the FIFO still accepts words until full; the current frame finishes; no new frame starts.
- tx_busy_o = (state != IDLE) | FIFO non-empty, combinational.

## Timing
- Reset values: tx_o = 1, tx_busy_o = 0, tx_div_clk_en_o = 0, tx_ready_o = 1 (FIFO empty), FSM IDLE, FIFO empty, shift register 0.
- Reset mid-frame: tx_o returns to 1 immediately (asynchronous) and FIFO contents are discarded.
- Latency: a word accepted at edge E0 with the FSM idle and FIFO empty gives tx_o low from edge E1, one cycle later.
- Frame length, start-bit falling edge to end of stop bit: exactly 10·BAUD_DIVIDER cycles, or 11·BAUD_DIVIDER with parity.
- Back-to-back frames: the next start bit begins on the cycle after the last stop cycle.
- Pop on the FIFO-full cycle: tx_ready_o rises on the following cycle.

## Configuration
- UART_TX_PARITY_EN defined: PARITY state present; even parity bit inserted after data bit 7; frame is 11 bits.
- UART_TX_PARITY_EN undefined: PARITY state and logic absent; frame is 10 bits (8N1).

## Structure
- Package uart_pkg:
  - FSM state typedef (IDLE, START, DATA, PARITY, STOP)
  - default BAUD_DIVIDER constant
  - data width 8
  - frame-length constants
- Sub-module uart_tx_fifo: synchronous FIFO, parameter FIFO_DEPTH; ports push/pop/full/empty/data.
- FSM, baud counter and shift register live in uart_tx.

## Test plan
- Idle after reset → tx_o = 1, tx_ready_o = 1, tx_busy_o = 0.
- Single frame, BAUD_DIVIDER = 4, send 8'hA5:
  - tx_o low 1 cycle after accept.
  - Sampling each bit mid-period reads 0,1,0,1,0,0,1,0,1,1 (start, data LSB first, stop).
  - Frame is 40 cycles.
- Burst: push 5 words back-to-back with FIFO_DEPTH = 4:
  - tx_ready_o drops at 4 queued words (first word already popped → accepts 5th, then stalls).
  - Frames emitted with no idle gap.
  - Bytes arrive in order.
- en_i low while a word is queued → tx_o stays 1 and tx_busy_o = 1; raising en_i starts the frame 1 cycle later.
- Reset asserted mid-DATA → tx_o = 1 immediately; after release tx_busy_o = 0 and no further frames.
- UART_TX_PARITY_EN: send 8'h07 → parity bit = 1, frame 11·BAUD_DIVIDER cycles. Send 8'h03 → parity bit = 0.
